// File: rtl/hs_inband_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : hs_inband_fetch_if
// Description : Bus bundle for the inband ring consumer. It holds the burst
//               read channel (rd_*), the consumer index writeback channel
//               (wr_*) and the outbound entry word stream (ent_*).
//               master : the fetch engine side
//               slave  : memory / downstream consumer side
// Revision    : 1.0 - initial release
// ============================================================================
interface hs_inband_fetch_if;
    // Burst read: request/ack, then ENTRY_WORDS in-order return words
    logic        rd_req;
    logic        rd_ack;
    logic [31:0] rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    // Single-word consumer index writeback
    logic        wr_req;
    logic        wr_ack;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    // Entry word stream
    logic        ent_valid;
    logic        ent_ready;
    logic [31:0] ent_data;
    logic        ent_last;

    modport master (
        output rd_req, rd_addr,
        input  rd_ack, rd_valid, rd_data,
        output wr_req, wr_addr, wr_data,
        input  wr_ack,
        output ent_valid, ent_data, ent_last,
        input  ent_ready
    );

    modport slave (
        input  rd_req, rd_addr,
        output rd_ack, rd_valid, rd_data,
        input  wr_req, wr_addr, wr_data,
        output wr_ack,
        input  ent_valid, ent_data, ent_last,
        output ent_ready
    );
endinterface
`default_nettype wire

// File: rtl/hs_inband_fetch.sv
`default_nettype none
// ============================================================================
// Module      : hs_inband_fetch
// Description : Inband ring consumer. Fetches ring entries (ENTRY_WORDS x 32b)
//               from host memory into a local word FIFO, streams them out as
//               a valid/ready word stream with an end-of-entry tag, and writes
//               the consumer index back to host memory.
// Ports       : sys_clk, sys_rst_n (async, active-low)
//               ring_enable, inband_base, inband_cons_addr, inband_prod_index
//               inband_cons_index : entries fetched, modulo ring size
//               busy              : FSM not idle or FIFO holding words
//               bus               : hs_inband_fetch_if.master (rd/wr/ent)
// Options     : HS_INBAND_WB_BATCH_EN - coalesce writebacks; one write per
//               WB_BATCH entries or when the ring has been drained.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_inband_fetch #(
    parameter int RING_AW     = 8,
    parameter int ENTRY_WORDS = 4,
    parameter int FIFO_AW     = 4,
    parameter int WB_BATCH    = 8
) (
    input  wire logic        sys_clk,
    input  wire logic        sys_rst_n,
    input  wire logic        ring_enable,
    input  wire logic [31:0] inband_base,
    input  wire logic [31:0] inband_cons_addr,
    input  wire logic [11:0] inband_prod_index,
    output logic      [11:0] inband_cons_index,
    output logic             busy,
    hs_inband_fetch_if.master bus
);

    localparam int c_DEPTH   = 2 ** FIFO_AW;
    localparam int c_SHIFT   = $clog2(ENTRY_WORDS) + 2;
    localparam int c_BEAT_W  = (ENTRY_WORDS > 1) ? $clog2(ENTRY_WORDS) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(ENTRY_WORDS - 1);
    // A new burst is only started if the whole entry fits behind what is queued
    localparam logic [FIFO_AW:0]    c_SPACE_MAX = (FIFO_AW + 1)'(c_DEPTH - ENTRY_WORDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_REQ  = 2'd1,
        S_RD_DATA = 2'd2,
        S_WB_REQ  = 2'd3
    } state_t;

    state_t              state_q;
    logic [RING_AW-1:0]  cons_q;
    logic [c_BEAT_W-1:0] beat_q;
    logic                discard_q;
    logic                rd_req_q;
    logic [31:0]         rd_addr_q;
    logic                wr_req_q;
    logic [31:0]         wr_addr_q;
    logic [31:0]         wr_data_q;

    logic [32:0]         mem_q [c_DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q;
    logic [FIFO_AW-1:0]  rd_ptr_q;
    logic [FIFO_AW:0]    count_q;
    logic [FIFO_AW:0]    count_d;

    logic [RING_AW-1:0]  w_prod;
    logic [RING_AW-1:0]  w_cons_inc;
    logic                w_last_beat;
    logic                w_space;
    logic                w_push;
    logic                w_pop;
    logic                w_valid;
    logic                w_wb_go;

    assign w_prod      = inband_prod_index[RING_AW-1:0];
    assign w_cons_inc  = cons_q + RING_AW'(1);
    assign w_last_beat = (beat_q == c_LAST_BEAT);
    assign w_space     = (count_q <= c_SPACE_MAX);

    generate
        if (RING_AW < 12) begin : g_prod_hi
            wire w_unused_prod_hi = ^inband_prod_index[11:RING_AW];
        end
    endgenerate

`ifdef HS_INBAND_WB_BATCH_EN
    localparam int c_BATCH_W = $clog2(WB_BATCH + 1);
    logic [c_BATCH_W-1:0] batch_q;
    logic [c_BATCH_W-1:0] w_batch_inc;
    logic [RING_AW-1:0]   prod_q;

    assign w_batch_inc = batch_q + c_BATCH_W'(1);
    // Write back on a full batch, or once this entry drains the ring
    assign w_wb_go     = (w_batch_inc == c_BATCH_W'(WB_BATCH)) || (prod_q == w_cons_inc);
`else
    localparam int c_unused_batch = WB_BATCH;
    assign w_wb_go = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Fetch / writeback FSM
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            cons_q    <= '0;
            beat_q    <= '0;
            discard_q <= 1'b0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef HS_INBAND_WB_BATCH_EN
            batch_q   <= '0;
            prod_q    <= '0;
`endif
        end else begin
            // A disabled ring restarts from index 0; the writeback payload is
            // already captured so an in-flight write is unaffected.
            if (!ring_enable) begin
                cons_q <= '0;
`ifdef HS_INBAND_WB_BATCH_EN
                batch_q <= '0;
`endif
            end

            case (state_q)
                S_IDLE: begin
                    if (ring_enable && (w_prod != cons_q) && w_space) begin
                        state_q   <= S_RD_REQ;
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= inband_base + (32'(cons_q) << c_SHIFT);
`ifdef HS_INBAND_WB_BATCH_EN
                        prod_q    <= w_prod;
`endif
                    end
                end

                S_RD_REQ: begin
                    if (!ring_enable) begin
                        state_q  <= S_IDLE;
                        rd_req_q <= 1'b0;
                    end else if (bus.rd_ack) begin
                        state_q   <= S_RD_DATA;
                        rd_req_q  <= 1'b0;
                        beat_q    <= '0;
                        discard_q <= 1'b0;
                    end
                end

                S_RD_DATA: begin
                    // Once disabled mid-burst, the rest of the burst is still
                    // drained from the bus but never lands in the FIFO.
                    if (!ring_enable) begin
                        discard_q <= 1'b1;
                    end
                    if (bus.rd_valid) begin
                        beat_q <= beat_q + c_BEAT_W'(1);
                        if (w_last_beat) begin
                            discard_q <= 1'b0;
                            if (discard_q || !ring_enable) begin
                                state_q <= S_IDLE;
                            end else begin
                                cons_q <= w_cons_inc;
                                if (w_wb_go) begin
                                    state_q   <= S_WB_REQ;
                                    wr_req_q  <= 1'b1;
                                    wr_addr_q <= inband_cons_addr;
                                    wr_data_q <= 32'(w_cons_inc);
`ifdef HS_INBAND_WB_BATCH_EN
                                    batch_q   <= '0;
`endif
                                end else begin
                                    state_q <= S_IDLE;
`ifdef HS_INBAND_WB_BATCH_EN
                                    batch_q <= w_batch_inc;
`endif
                                end
                            end
                        end
                    end
                end

                S_WB_REQ: begin
                    if (bus.wr_ack) begin
                        state_q  <= S_IDLE;
                        wr_req_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO (data + end-of-entry tag)
    // ------------------------------------------------------------------
    assign w_push  = (state_q == S_RD_DATA) && bus.rd_valid && !discard_q && ring_enable;
    assign w_valid = (count_q != '0) && ring_enable;
    assign w_pop   = w_valid && bus.ent_ready;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {w_last_beat, bus.rd_data};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (!ring_enable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs; FIFO read data is masked so idle outputs read as zero
    // ------------------------------------------------------------------
    assign bus.rd_req    = rd_req_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.wr_req    = wr_req_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.ent_valid = w_valid;
    assign bus.ent_data  = w_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
    assign bus.ent_last  = w_valid ? mem_q[rd_ptr_q][32]   : 1'b0;

    assign inband_cons_index = 12'(cons_q);
    assign busy              = (state_q != S_IDLE) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_hs_inband_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hs_inband_fetch
// Description : Self-checking bench for hs_inband_fetch. A memory model
//               answers read bursts and writebacks; expected read addresses,
//               entry words and writeback values are queued by a ring model
//               and compared when the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_inband_fetch;

    localparam int          RING_AW     = 8;
    localparam int          ENTRY_WORDS = 4;
    localparam int          FIFO_AW     = 4;
    localparam int          WB_BATCH    = 8;
    localparam int          RING_SIZE   = 2 ** RING_AW;
    localparam logic [31:0] CONS_ADDR   = 32'hC0DE_0040;

    typedef struct {
        logic [31:0] base;
        logic [11:0] prod;
        logic [11:0] exp_cons;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        ring_en_main = 1'b0;
    logic        force_dis;
    logic        dis_arm = 1'b0;
    logic        wr_hold = 1'b0;
    logic [31:0] base = 32'h0;
    logic [31:0] cons_addr = CONS_ADDR;
    logic [11:0] prod = 12'h0;
    logic [11:0] cons_idx;
    logic        busy;
    wire         ring_enable = ring_en_main & ~force_dis;

    int checks = 0;
    int failures = 0;
    int rd_bursts = 0;
    int wr_count = 0;
    int words_seen = 0;
    int m_cons = 0;
    int m_batch = 0;

    logic [31:0] exp_raddr_q [$];
    logic [32:0] exp_word_q  [$];
    logic [31:0] exp_wb_q    [$];

    vec_t vecs [5];

    hs_inband_fetch_if bus ();

    hs_inband_fetch #(
        .RING_AW     (RING_AW),
        .ENTRY_WORDS (ENTRY_WORDS),
        .FIFO_AW     (FIFO_AW),
        .WB_BATCH    (WB_BATCH)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rst_n         (sys_rst_n),
        .ring_enable       (ring_enable),
        .inband_base       (base),
        .inband_cons_addr  (cons_addr),
        .inband_prod_index (prod),
        .inband_cons_index (cons_idx),
        .busy              (busy),
        .bus               (bus)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Ring model: queue everything the DUT must produce to reach 'target'
    task automatic push_entries(input int target);
        logic [31:0] a;
        while (m_cons != target) begin
            a = base + 32'(m_cons * ENTRY_WORDS * 4);
            exp_raddr_q.push_back(a);
            for (int w = 0; w < ENTRY_WORDS; w++)
                exp_word_q.push_back({(w == ENTRY_WORDS - 1), mem_word(a + 32'(4 * w))});
            m_cons = (m_cons + 1) % RING_SIZE;
`ifdef HS_INBAND_WB_BATCH_EN
            m_batch++;
            if (m_batch == WB_BATCH || m_cons == target) begin
                exp_wb_q.push_back(32'(m_cons));
                m_batch = 0;
            end
`else
            exp_wb_q.push_back(32'(m_cons));
`endif
        end
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!(busy == 1'b0 && exp_raddr_q.size() == 0 && exp_word_q.size() == 0 &&
                     exp_wb_q.size() == 0) && n < bound);
        if (n >= bound) fail_now({name, " timeout waiting for idle"});
    endtask

    // Memory model: read bursts, ack one cycle after the request
    initial begin : rd_resp
        logic [31:0] a;
        force_dis     = 1'b0;
        bus.rd_ack    = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_data   = 32'h0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (!dis_arm) force_dis = 1'b0;
            if (bus.rd_req === 1'b1) begin
                a = bus.rd_addr;
                rd_bursts++;
                if (exp_raddr_q.size() == 0) fail_now("rd_addr unexpected burst");
                else check("rd_addr", a, exp_raddr_q.pop_front());
                bus.rd_ack = 1'b1;
                @(posedge sys_clk);
                #1;
                bus.rd_ack = 1'b0;
                for (int w = 0; w < ENTRY_WORDS; w++) begin
                    if (dis_arm && w == 2) force_dis = 1'b1;
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = mem_word(a + 32'(4 * w));
                    @(posedge sys_clk);
                    #1;
                end
                bus.rd_valid = 1'b0;
                bus.rd_data  = 32'h0;
            end
        end
    end

    // Memory model: consumer index writebacks
    initial begin : wr_resp
        bus.wr_ack = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (bus.wr_req === 1'b1 && !wr_hold) begin
                wr_count++;
                check("wr_addr", bus.wr_addr, CONS_ADDR);
                if (exp_wb_q.size() == 0) fail_now("wr_data unexpected writeback");
                else check("wr_data", bus.wr_data, exp_wb_q.pop_front());
                bus.wr_ack = 1'b1;
                @(posedge sys_clk);
                #1;
                bus.wr_ack = 1'b0;
            end
        end
    end

    // Entry stream sink
    always @(negedge sys_clk) begin : sink
        logic [32:0] e;
        if (sys_rst_n && bus.ent_valid === 1'b1 && bus.ent_ready === 1'b1) begin
            words_seen++;
            if (exp_word_q.size() == 0) begin
                fail_now("ent_data unexpected word");
            end else begin
                e = exp_word_q.pop_front();
                check("ent_data", bus.ent_data, e[31:0]);
                check("ent_last", 32'(bus.ent_last), 32'(e[32]));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int b0;
        int w0;
        int n;

        vecs[0] = '{base: 32'h0000_1000, prod: 12'd1,   exp_cons: 12'd1};
        vecs[1] = '{base: 32'h0000_1000, prod: 12'd5,   exp_cons: 12'd5};
        vecs[2] = '{base: 32'h0000_2000, prod: 12'd9,   exp_cons: 12'd9};
        vecs[3] = '{base: 32'h0000_2000, prod: 12'd255, exp_cons: 12'd255};
        vecs[4] = '{base: 32'h0000_2000, prod: 12'd1,   exp_cons: 12'd1};

        bus.ent_ready = 1'b0;
        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("reset rd_req",    32'(bus.rd_req),    32'h0);
        check("reset wr_req",    32'(bus.wr_req),    32'h0);
        check("reset ent_valid", 32'(bus.ent_valid), 32'h0);
        check("reset cons",      32'(cons_idx),      32'h0);
        check("reset busy",      32'(busy),          32'h0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        ring_en_main  = 1'b1;
        bus.ent_ready = 1'b1;

        // Table: single entry, multi entry, new base, run up to 255, wrap
        for (int i = 0; i < 5; i++) begin
            base = vecs[i].base;
            push_entries(int'(vecs[i].prod));
            prod = vecs[i].prod;
            wait_idle(6000, $sformatf("row%0d", i));
            check($sformatf("row%0d cons", i), 32'(cons_idx), 32'(vecs[i].exp_cons));
            check($sformatf("row%0d busy", i), 32'(busy), 32'h0);
        end

        // Backpressure: only a FIFO's worth of entries fetched while stalled
        bus.ent_ready = 1'b0;
        base = 32'h0000_3000;
        push_entries(11);
        b0 = rd_bursts;
        w0 = words_seen;
        prod = 12'd11;
        repeat (300) @(negedge sys_clk);
        check("bp bursts while stalled", 32'(rd_bursts - b0), 32'd4);
        check("bp rd_req while stalled", 32'(bus.rd_req), 32'h0);
        check("bp ent_valid while stalled", 32'(bus.ent_valid), 32'h1);
        bus.ent_ready = 1'b1;
        wait_idle(3000, "bp");
        check("bp words delivered", 32'(words_seen - w0), 32'd40);
        check("bp cons", 32'(cons_idx), 32'd11);

        // Disable after word 2 of 4
        bus.ent_ready = 1'b0;
        dis_arm = 1'b1;
        exp_raddr_q.push_back(base + 32'(m_cons * ENTRY_WORDS * 4));
        w0 = wr_count;
        prod = 12'd12;
        n = 0;
        while (force_dis !== 1'b1 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 200) fail_now("dis timeout waiting for disable");
        repeat (10) @(negedge sys_clk);
        check("dis no writeback", 32'(wr_count - w0), 32'h0);
        check("dis busy", 32'(busy), 32'h0);
        check("dis cons", 32'(cons_idx), 32'h0);
        check("dis ent_valid", 32'(bus.ent_valid), 32'h0);
        check("dis read consumed", 32'(exp_raddr_q.size()), 32'h0);
        m_cons  = 0;
        m_batch = 0;
        prod    = 12'd0;
        dis_arm = 1'b0;
        bus.ent_ready = 1'b1;
        repeat (5) @(negedge sys_clk);

        // 20 entries from 0: writeback coalescing (or one per entry)
        base = 32'h0000_1000;
        w0 = wr_count;
        push_entries(20);
        prod = 12'd20;
        wait_idle(3000, "batch");
        check("batch cons", 32'(cons_idx), 32'd20);
`ifdef HS_INBAND_WB_BATCH_EN
        check("batch writebacks", 32'(wr_count - w0), 32'd3);
`else
        check("batch writebacks", 32'(wr_count - w0), 32'd20);
`endif

        // Async reset while a writeback is pending
        wr_hold = 1'b1;
        push_entries(21);
        prod = 12'd21;
        n = 0;
        while (bus.wr_req !== 1'b1 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 200) fail_now("rst timeout waiting for wr_req");
        #2 sys_rst_n = 1'b0;
        #1;
        check("rst wr_req",    32'(bus.wr_req),    32'h0);
        check("rst wr_addr",   bus.wr_addr,        32'h0);
        check("rst wr_data",   bus.wr_data,        32'h0);
        check("rst rd_req",    32'(bus.rd_req),    32'h0);
        check("rst rd_addr",   bus.rd_addr,        32'h0);
        check("rst ent_valid", 32'(bus.ent_valid), 32'h0);
        check("rst ent_data",  bus.ent_data,       32'h0);
        check("rst ent_last",  32'(bus.ent_last),  32'h0);
        check("rst busy",      32'(busy),          32'h0);
        check("rst cons",      32'(cons_idx),      32'h0);
        exp_raddr_q.delete();
        exp_word_q.delete();
        exp_wb_q.delete();
        m_cons  = 0;
        m_batch = 0;
        wr_hold = 1'b0;
        prod    = 12'd0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        b0 = rd_bursts;
        w0 = wr_count;
        repeat (40) @(negedge sys_clk);
        check("post-rst no reads",  32'(rd_bursts - b0), 32'h0);
        check("post-rst no writes", 32'(wr_count - w0),  32'h0);
        check("post-rst busy",      32'(busy),           32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
